// File: rtl/vx_wb_arbiter.sv
// vx_wb_arbiter -- writeback arbiter between the execute units and the
// scoreboard / operand register file.
//
// Picks at most one result beat per cycle from NUM_INPUTS execute-unit ports
// using round-robin priority. Once a unit starts a multi-beat packet (eop=0)
// the arbiter stays locked to that unit until its eop=1 beat is accepted.
// The chosen beat is registered onto out_data one cycle later. out_valid is
// raised only for beats that carry wb=1. There is no downstream backpressure.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_valid     [NUM_INPUTS]        per-unit result beat valid
//   in_data      [NUM_INPUTS*DATAW]  per-unit beat, unit i at [i*DATAW +: DATAW]
//   in_ready     [NUM_INPUTS]        per-unit accept, one-hot or zero
//   out_valid                        writeback beat valid
//   out_data     [DATAW]             registered writeback beat
//   perf_commits [PERF_CTR_BITS]     (WB_ARB_PERF_EN only) accepted eop=1 beats
//   perf_stalls  [PERF_CTR_BITS]     (WB_ARB_PERF_EN only) cycles with a valid
//                                    input left unaccepted
//
// Build option: define WB_ARB_PERF_EN to add the two performance counters.
//
// Beat layout, MSB to LSB: uuid, wid, PC, tmask, rd, wb, data, eop.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_OPEN   | no packet in flight; round-robin search from last_grant+1
// ST_LOCKED | packet in flight from lock_idx; only that unit is eligible

`ifndef XLEN
`define XLEN 32
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef UUID_WIDTH
`define UUID_WIDTH 44
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

module vx_wb_arbiter #(
  parameter int CORE_ID    = 0,
  parameter int NUM_INPUTS = 4,
  parameter int THREAD_CNT = `NUM_THREADS,
  localparam int DATAW = `UUID_WIDTH + `NW_BITS + `XLEN + THREAD_CNT + `NR_BITS
                         + 1 + THREAD_CNT * `XLEN + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS-1:0]       in_valid,
  input  logic [NUM_INPUTS*DATAW-1:0] in_data,
  output logic [NUM_INPUTS-1:0]       in_ready,
  output logic                        out_valid,
  output logic [DATAW-1:0]            out_data
`ifdef WB_ARB_PERF_EN
  ,
  output logic [`PERF_CTR_BITS-1:0]   perf_commits,
  output logic [`PERF_CTR_BITS-1:0]   perf_stalls
`endif
);

  localparam int IDXW   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int WB_BIT = THREAD_CNT * `XLEN + 1;

  // CORE_ID only tags this instance for debug; it is folded into the
  // elaboration check so an illegal configuration stops the build.
  if (NUM_INPUTS < 2 || NUM_INPUTS > 8 || CORE_ID < 0) begin : g_bad_params
    $error("vx_wb_arbiter: NUM_INPUTS must be 2..8 and CORE_ID non-negative");
  end

  typedef enum logic {
    ST_OPEN,
    ST_LOCKED
  } state_e;

  state_e                state;
  logic [IDXW-1:0]       last_grant;
  logic [IDXW-1:0]       lock_idx;
  logic [IDXW-1:0]       grant_idx;
  logic                  grant_found;
  logic                  fire;
  logic [NUM_INPUTS-1:0] grant_oh;
  logic [DATAW-1:0]      fire_data;

  function automatic logic [IDXW-1:0] rr_idx(input logic [IDXW-1:0] base,
                                             input int k);
    int s;
    s = (int'(base) + 1 + k) % NUM_INPUTS;
    return s[IDXW-1:0];
  endfunction

  // While locked, a missing beat from the owner leaves the port idle rather
  // than letting another unit interleave into the packet.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    if (state == ST_LOCKED) begin
      grant_idx   = lock_idx;
      grant_found = in_valid[lock_idx];
    end else begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        if (!grant_found && in_valid[rr_idx(last_grant, k)]) begin
          grant_found = 1'b1;
          grant_idx   = rr_idx(last_grant, k);
        end
      end
    end
  end

  // Nothing is accepted in a reset cycle, so a packet cut by reset is dropped.
  assign fire      = grant_found && !reset;
  assign fire_data = in_data[int'(grant_idx)*DATAW +: DATAW];

  always_comb begin
    grant_oh = '0;
    if (fire) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  assign in_ready = grant_oh;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_OPEN;
      lock_idx   <= '0;
      last_grant <= IDXW'(NUM_INPUTS - 1);
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      out_valid <= fire && fire_data[WB_BIT];
      if (fire) begin
        // wb=0 beats still land in out_data; only out_valid stays low.
        out_data   <= fire_data;
        last_grant <= grant_idx;
        if (fire_data[0]) begin
          state <= ST_OPEN;
        end else begin
          state    <= ST_LOCKED;
          lock_idx <= grant_idx;
        end
      end
    end
  end

`ifdef WB_ARB_PERF_EN
  localparam int PCW = `PERF_CTR_BITS;

  logic stall_cycle;
  assign stall_cycle = |(in_valid & ~in_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_commits <= '0;
      perf_stalls  <= '0;
    end else begin
      if (fire && fire_data[0]) begin
        perf_commits <= perf_commits + PCW'(1);
      end
      if (stall_cycle) begin
        perf_stalls <= perf_stalls + PCW'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_vx_wb_arbiter.sv
// tb_vx_wb_arbiter -- self-checking bench for vx_wb_arbiter (4 inputs).
// Table of {in_valid, eop, wb, expected in_ready} vectors applied in order,
// plus hand-written sequences for field integrity and reset mid-packet.
// Expected writeback beats go into a scoreboard queue when stimulus is driven
// and are popped and compared one cycle later.

`timescale 1ns/1ps

`ifndef XLEN
`define XLEN 32
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef UUID_WIDTH
`define UUID_WIDTH 44
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

module tb_vx_wb_arbiter;

  localparam int NI     = 4;
  localparam int TC     = `NUM_THREADS;
  localparam int XL     = `XLEN;
  localparam int UW     = `UUID_WIDTH;
  localparam int NWB    = `NW_BITS;
  localparam int NRB    = `NR_BITS;
  localparam int DATAW  = UW + NWB + XL + TC + NRB + 1 + TC*XL + 1;
  localparam int WB_BIT = TC*XL + 1;
  localparam int RD_LSB = TC*XL + 2;
  localparam int TM_LSB = RD_LSB + NRB;
  localparam int PC_LSB = TM_LSB + TC;
  localparam int WID_LSB = PC_LSB + XL;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NI-1:0]          in_valid = '0;
  logic [NI*DATAW-1:0]    in_data = '0;
  logic [NI-1:0]          in_ready;
  logic                   out_valid;
  logic [DATAW-1:0]       out_data;
`ifdef WB_ARB_PERF_EN
  logic [`PERF_CTR_BITS-1:0] perf_commits;
  logic [`PERF_CTR_BITS-1:0] perf_stalls;
  logic [`PERF_CTR_BITS-1:0] exp_commits;
  logic [`PERF_CTR_BITS-1:0] exp_stalls;
`endif

  always #5 clk = ~clk;

  vx_wb_arbiter #(
    .CORE_ID    (0),
    .NUM_INPUTS (NI),
    .THREAD_CNT (TC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data)
`ifdef WB_ARB_PERF_EN
    ,
    .perf_commits (perf_commits),
    .perf_stalls  (perf_stalls)
`endif
  );

  typedef struct packed {
    logic [NI-1:0] valid;
    logic [NI-1:0] eop;
    logic [NI-1:0] wb;
    logic [NI-1:0] exp_ready;
  } vec_t;

  typedef struct packed {
    logic             v;
    logic [DATAW-1:0] d;
  } exp_t;

  int               checks = 0;
  int               errors = 0;
  vec_t             vecs[$];
  exp_t             sb_q[$];
  logic [DATAW-1:0] beats [NI];
  logic [DATAW-1:0] last_exp_d = '0;

  task automatic chk(input string name, input logic [DATAW-1:0] act,
                     input logic [DATAW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATAW-1:0] mk_beat(
      input logic [UW-1:0] uuid, input logic [NWB-1:0] wid,
      input logic [XL-1:0] pc, input logic [TC-1:0] tm,
      input logic [NRB-1:0] rd, input logic wb,
      input logic [TC*XL-1:0] data, input logic eop);
    return {uuid, wid, pc, tm, rd, wb, data, eop};
  endfunction

  task automatic fill_beats(input int tag, input logic [NI-1:0] eop,
                            input logic [NI-1:0] wb);
    logic [TC*XL-1:0] d;
    for (int i = 0; i < NI; i++) begin
      for (int l = 0; l < TC; l++) d[l*XL +: XL] = XL'(tag*4096 + i*256 + l);
      beats[i] = mk_beat(UW'(tag*8 + i), NWB'(i), XL'(32'h1000 + tag*16 + i*4),
                         {TC{1'b1}}, NRB'(i + 1), wb[i], d, eop[i]);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < NI; i++) in_data[i*DATAW +: DATAW] = beats[i];
  endtask

  task automatic step(input string name, input logic [NI-1:0] v,
                      input logic [NI-1:0] exp_ready);
    exp_t e;
    exp_t got;
    int   idx;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = v;
    drive_data();
    #1;
    chk({name, " in_ready"}, DATAW'(in_ready), DATAW'(exp_ready));
    idx = 0;
    for (int k = 0; k < NI; k++) if (exp_ready[k]) idx = k;
    if (exp_ready != '0) begin
      e.v = beats[idx][WB_BIT];
      e.d = beats[idx];
      last_exp_d = beats[idx];
`ifdef WB_ARB_PERF_EN
      if (beats[idx][0]) exp_commits = exp_commits + 1'b1;
`endif
    end else begin
      e.v = 1'b0;
      e.d = last_exp_d;
    end
`ifdef WB_ARB_PERF_EN
    if (|(v & ~exp_ready)) exp_stalls = exp_stalls + 1'b1;
`endif
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", name);
    end else begin
      got = sb_q.pop_front();
      chk({name, " out_valid"}, DATAW'(out_valid), DATAW'(got.v));
      chk({name, " out_data"}, out_data, got.d);
    end
`ifdef WB_ARB_PERF_EN
    chk({name, " perf_commits"}, DATAW'(perf_commits), DATAW'(exp_commits));
    chk({name, " perf_stalls"}, DATAW'(perf_stalls), DATAW'(exp_stalls));
`endif
  endtask

  // Leaves reset asserted; the next step() releases it at its drive edge.
  task automatic do_reset(input logic [NI-1:0] v);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = v;
    drive_data();
    #1;
    chk("reset in_ready", DATAW'(in_ready), '0);
    @(posedge clk);
    #1;
    chk("reset out_valid", DATAW'(out_valid), '0);
    chk("reset out_data", out_data, '0);
    sb_q.delete();
    last_exp_d = '0;
`ifdef WB_ARB_PERF_EN
    chk("reset perf_commits", DATAW'(perf_commits), '0);
    chk("reset perf_stalls", DATAW'(perf_stalls), '0);
    exp_commits = '0;
    exp_stalls  = '0;
`endif
  endtask

  task automatic add(input logic [NI-1:0] v, input logic [NI-1:0] eop,
                     input logic [NI-1:0] wb, input logic [NI-1:0] r);
    vec_t t;
    t.valid = v; t.eop = eop; t.wb = wb; t.exp_ready = r;
    vecs.push_back(t);
  endtask

  initial begin
    // priority after reset: 0,1,2,3,0 with continuous out_valid
    add(4'b1111, 4'b1111, 4'b1111, 4'b0001);
    add(4'b1111, 4'b1111, 4'b1111, 4'b0010);
    add(4'b1111, 4'b1111, 4'b1111, 4'b0100);
    add(4'b1111, 4'b1111, 4'b1111, 4'b1000);
    add(4'b1111, 4'b1111, 4'b1111, 4'b0001);
    // input 2 packet eop 0,0,1 with input 0 waiting
    add(4'b0101, 4'b1011, 4'b1111, 4'b0100);
    add(4'b0101, 4'b1011, 4'b1111, 4'b0100);
    add(4'b0101, 4'b1111, 4'b1111, 4'b0100);
    add(4'b0001, 4'b1111, 4'b1111, 4'b0001);
    // wb=0 beat on input 0, then idle (out_data held)
    add(4'b0001, 4'b1111, 4'b1110, 4'b0001);
    add(4'b0000, 4'b1111, 4'b1111, 4'b0000);
    // input 1 locked with a 2-cycle gap while input 3 waits
    add(4'b0010, 4'b1101, 4'b1111, 4'b0010);
    add(4'b1000, 4'b1101, 4'b1111, 4'b0000);
    add(4'b1000, 4'b1101, 4'b1111, 4'b0000);
    add(4'b1010, 4'b1111, 4'b1111, 4'b0010);
    add(4'b1000, 4'b1111, 4'b1111, 4'b1000);
    // round-robin rotation over sparse patterns, mixed wb
    add(4'b1010, 4'b1111, 4'b1111, 4'b0010);
    add(4'b1010, 4'b1111, 4'b1111, 4'b1000);
    add(4'b0110, 4'b1111, 4'b0101, 4'b0010);
    add(4'b0110, 4'b1111, 4'b0101, 4'b0100);
    add(4'b0110, 4'b1111, 4'b0101, 4'b0010);
    add(4'b1111, 4'b1111, 4'b1111, 4'b0100);
    add(4'b1111, 4'b1111, 4'b1111, 4'b1000);

`ifdef WB_ARB_PERF_EN
    exp_commits = '0;
    exp_stalls  = '0;
`endif
    fill_beats(0, 4'b1111, 4'b1111);
    do_reset(4'b1111);
    do_reset(4'b1111);

    for (int i = 0; i < vecs.size(); i++) begin
      fill_beats(i + 1, vecs[i].eop, vecs[i].wb);
      step($sformatf("vec%0d", i), vecs[i].valid, vecs[i].exp_ready);
    end

    // field integrity through input 3 (last_grant is 3, so search wraps to 3)
    begin
      logic [TC*XL-1:0] d;
      fill_beats(200, 4'b1111, 4'b1111);
      d = '0;
      d[XL-1:0] = XL'(32'hDEADBEEF);
      beats[3] = mk_beat(UW'(44'h123), NWB'(1), XL'(32'h8000_0040), TC'(1),
                         NRB'(5), 1'b1, d, 1'b1);
      step("data3", 4'b1000, 4'b1000);
      chk("data3 rd", DATAW'(out_data[RD_LSB +: NRB]), DATAW'(5));
      chk("data3 wid", DATAW'(out_data[WID_LSB +: NWB]), DATAW'(1));
      chk("data3 lane0", DATAW'(out_data[XL:1]), DATAW'(32'hDEADBEEF));
      chk("data3 wb", DATAW'(out_data[WB_BIT]), DATAW'(1));
      chk("data3 eop", DATAW'(out_data[0]), DATAW'(1));
    end

    // reset while input 2 holds the lock; input 0 must win afterwards
    fill_beats(300, 4'b1011, 4'b1111);
    step("lock2", 4'b0100, 4'b0100);
    do_reset(4'b0101);
    fill_beats(301, 4'b1111, 4'b1111);
    step("post_rst0", 4'b0101, 4'b0001);
    step("post_rst1", 4'b0101, 4'b0100);
    step("idle", 4'b0000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
